// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared definitions for the pipeline sequencing controller of the 5-stage
// MIPS core: the controller state encoding, the hard-wired zero register
// index and the default values of the controller parameters.
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  // Controller states. RUN is the normal sequencing state, WAIT tracks a
  // data-memory wait in progress, ERR is the sticky watchdog error state.
  typedef enum logic [1:0] {
    S_RUN  = 2'b00,
    S_WAIT = 2'b01,
    S_ERR  = 2'b10
  } state_t;

  // Register $zero is never a real producer, so it never causes a hazard.
  localparam logic [4:0] ZERO_REG = 5'd0;

  // Default parameter values.
  localparam int MDU_LAT_DEF = 32;
  localparam int MEM_TO_DEF  = 255;
  localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/pipe_ctrl_mdu.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_mdu (multiply/divide busy timer)
// Counts down the remaining latency of an in-flight mult/div so that
// instructions reading HI/LO, or starting another MDU operation, can be
// interlocked.
//
// Ports:
//   clk      in  pipeline clock, counter updates on the falling edge
//   rst      in  asynchronous active-high reset, clears the counter
//   i_load   in  launch pulse, loads the full latency
//   i_pause  in  pipeline frozen, counter holds its value
//   o_busy   out result pending (counter non-zero)
// ---------------------------------------------------------------------------
module pipe_ctrl_mdu
  import pipe_ctrl_pkg::*;
#(
  parameter int LAT = MDU_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_pause,
  output logic o_busy
);

  localparam int CW = $clog2(LAT + 1);

  logic [CW-1:0] r_cnt;

  // A launch reloads the full latency; otherwise the counter runs down by
  // one on every edge the pipeline is not frozen, stopping at zero.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CW'(LAT);
    end else if (!i_pause && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
// Pipeline sequencing controller. Drives the enable and flush controls of
// the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers and resolves, in
// priority order: watchdog error, data-memory freeze, branch redirect,
// load-use / MDU interlock stall and normal advance. It also owns the MDU
// busy timer, the memory-wait watchdog and a saturating stall counter.
// All state changes on the falling clock edge, the same edge as the
// pipeline registers, and every output is a combinational decode so a
// hazard acts on the very edge it is detected.
//
// Ports:
//   clk, rst            clock (falling edge) and async active-high reset
//   Id_rs, Id_rt        source registers of the instruction in ID
//   Ex_rt, Ex_MemRead   destination of the EX instruction, EX is a load
//   Mem_br_taken        branch/jump resolved taken in MEM
//   Id_mdu_start        ID instruction is mult/div
//   Id_mdu_use          ID instruction reads HI/LO
//   Mem_req, Mem_ready  data-memory handshake
//   Pc_en .. MemWb_en   pipeline register enables
//   IfId_flush, IdEx_flush, ExMem_flush  load a bubble
//   Mdu_go              one-cycle MDU launch
//   Mdu_busy            MDU result pending
//   Mem_err             sticky watchdog error
//   Stall_cnt           saturating count of non-advancing edges
// ---------------------------------------------------------------------------
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int MEM_TO  = MEM_TO_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Id_rs,
  input  logic [4:0]       Id_rt,
  input  logic [4:0]       Ex_rt,
  input  logic             Ex_MemRead,
  input  logic             Mem_br_taken,
  input  logic             Id_mdu_start,
  input  logic             Id_mdu_use,
  input  logic             Mem_req,
  input  logic             Mem_ready,
  output logic             Pc_en,
  output logic             IfId_en,
  output logic             IdEx_en,
  output logic             ExMem_en,
  output logic             MemWb_en,
  output logic             IfId_flush,
  output logic             IdEx_flush,
  output logic             ExMem_flush,
  output logic             Mdu_go,
  output logic             Mdu_busy,
  output logic             Mem_err,
  output logic [CNT_W-1:0] Stall_cnt
);

  localparam int WAIT_W = $clog2(MEM_TO + 1);

  state_t            r_state;
  state_t            w_stateNext;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [WAIT_W-1:0] w_waitNext;
  logic [CNT_W-1:0]  r_stallCnt;

  logic w_freeze;
  logic w_loadUse;
  logic w_mduStall;
  logic w_stall;
  logic w_active;
  logic w_mduBusy;

  logic w_pcEn;
  logic w_ifIdEn;
  logic w_idExEn;
  logic w_exMemEn;
  logic w_memWbEn;
  logic w_ifIdFlush;
  logic w_idExFlush;
  logic w_exMemFlush;
  logic w_go;

  // Hazard terms. A load only hurts the ID instruction if it really writes
  // a register that ID reads; $zero is excluded.
  assign w_freeze   = Mem_req & ~Mem_ready;
  assign w_loadUse  = Ex_MemRead && (Ex_rt != ZERO_REG) &&
                      ((Ex_rt == Id_rs) || (Ex_rt == Id_rt));
  assign w_mduStall = w_mduBusy & (Id_mdu_use | Id_mdu_start);
  assign w_stall    = w_loadUse | w_mduStall;

  // The pipeline can only move when not in reset, not in ERR and not
  // frozen by the data memory.
  assign w_active = ~rst && (r_state != S_ERR) && ~w_freeze;

  // State and wait counter registers.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_waitCnt <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_waitCnt <= w_waitNext;
    end
  end

  // Next-state decode. The wait counter holds the number of consecutive
  // frozen edges seen so far; the edge that brings it to MEM_TO while the
  // memory is still stuck moves the controller into ERR.
  always_comb begin
    w_stateNext = r_state;
    w_waitNext  = r_waitCnt;
    unique case (r_state)
      S_RUN: begin
        if (w_freeze) begin
          w_waitNext  = WAIT_W'(1);
          w_stateNext = (MEM_TO <= 1) ? S_ERR : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_freeze) begin
          w_waitNext = r_waitCnt + WAIT_W'(1);
          if ((int'(r_waitCnt) + 1) >= MEM_TO) begin
            w_stateNext = S_ERR;
          end
        end else begin
          w_waitNext  = '0;
          w_stateNext = S_RUN;
        end
      end
      S_ERR: begin
        w_stateNext = S_ERR;
      end
      default: begin
        w_stateNext = S_RUN;
        w_waitNext  = '0;
      end
    endcase
  end

  // Output decode. Everything defaults to "hold, no bubble"; a branch
  // redirect beats any stall in the same cycle, which is also why a
  // flushed mult/div never launches.
  always_comb begin
    w_pcEn       = 1'b0;
    w_ifIdEn     = 1'b0;
    w_idExEn     = 1'b0;
    w_exMemEn    = 1'b0;
    w_memWbEn    = 1'b0;
    w_ifIdFlush  = 1'b0;
    w_idExFlush  = 1'b0;
    w_exMemFlush = 1'b0;
    w_go         = 1'b0;
    if (w_active) begin
      if (Mem_br_taken) begin
        w_pcEn       = 1'b1;
        w_ifIdEn     = 1'b1;
        w_idExEn     = 1'b1;
        w_exMemEn    = 1'b1;
        w_memWbEn    = 1'b1;
        w_ifIdFlush  = 1'b1;
        w_idExFlush  = 1'b1;
        w_exMemFlush = 1'b1;
      end else if (w_stall) begin
        // Hold PC and IF/ID, inject a bubble into ID/EX, let older
        // instructions drain.
        w_idExEn    = 1'b1;
        w_exMemEn   = 1'b1;
        w_memWbEn   = 1'b1;
        w_idExFlush = 1'b1;
      end else begin
        w_pcEn    = 1'b1;
        w_ifIdEn  = 1'b1;
        w_idExEn  = 1'b1;
        w_exMemEn = 1'b1;
        w_memWbEn = 1'b1;
        w_go      = Id_mdu_start;
      end
    end
  end

  // MDU busy timer; a memory freeze pauses it.
  pipe_ctrl_mdu #(
    .LAT (MDU_LAT)
  ) u_mdu (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_go),
    .i_pause (w_freeze),
    .o_busy  (w_mduBusy)
  );

  // Every edge on which the PC does not advance is a lost cycle. The
  // counter sticks at all-ones rather than wrapping.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_stallCnt <= '0;
    end else if (!w_pcEn && (r_stallCnt != '1)) begin
      r_stallCnt <= r_stallCnt + CNT_W'(1);
    end
  end

  assign Pc_en       = w_pcEn;
  assign IfId_en     = w_ifIdEn;
  assign IdEx_en     = w_idExEn;
  assign ExMem_en    = w_exMemEn;
  assign MemWb_en    = w_memWbEn;
  assign IfId_flush  = w_ifIdFlush;
  assign IdEx_flush  = w_idExFlush;
  assign ExMem_flush = w_exMemFlush;
  assign Mdu_go      = w_go;
  assign Mdu_busy    = w_mduBusy;
  assign Mem_err     = (r_state == S_ERR);
  assign Stall_cnt   = r_stallCnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_ctrl
// Directed self-checking bench for pipe_ctrl with MDU_LAT=4, MEM_TO=4 and
// CNT_W=4. Inputs change just after each falling edge; outputs are checked
// two time units later, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_pipe_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] Id_rs;
  logic [4:0] Id_rt;
  logic [4:0] Ex_rt;
  logic       Ex_MemRead;
  logic       Mem_br_taken;
  logic       Id_mdu_start;
  logic       Id_mdu_use;
  logic       Mem_req;
  logic       Mem_ready;
  logic       Pc_en;
  logic       IfId_en;
  logic       IdEx_en;
  logic       ExMem_en;
  logic       MemWb_en;
  logic       IfId_flush;
  logic       IdEx_flush;
  logic       ExMem_flush;
  logic       Mdu_go;
  logic       Mdu_busy;
  logic       Mem_err;
  logic [3:0] Stall_cnt;

  int checks = 0;
  int errors = 0;

  // Expected control patterns: {Pc,IfId,IdEx,ExMem,MemWb} enables.
  localparam logic [4:0] EN_ALL   = 5'b11111;
  localparam logic [4:0] EN_NONE  = 5'b00000;
  localparam logic [4:0] EN_STALL = 5'b00111;
  // {IfId,IdEx,ExMem} flushes.
  localparam logic [2:0] FL_NONE  = 3'b000;
  localparam logic [2:0] FL_STALL = 3'b010;
  localparam logic [2:0] FL_ALL   = 3'b111;

  pipe_ctrl #(
    .MDU_LAT (4),
    .MEM_TO  (4),
    .CNT_W   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .Id_rs        (Id_rs),
    .Id_rt        (Id_rt),
    .Ex_rt        (Ex_rt),
    .Ex_MemRead   (Ex_MemRead),
    .Mem_br_taken (Mem_br_taken),
    .Id_mdu_start (Id_mdu_start),
    .Id_mdu_use   (Id_mdu_use),
    .Mem_req      (Mem_req),
    .Mem_ready    (Mem_ready),
    .Pc_en        (Pc_en),
    .IfId_en      (IfId_en),
    .IdEx_en      (IdEx_en),
    .ExMem_en     (ExMem_en),
    .MemWb_en     (MemWb_en),
    .IfId_flush   (IfId_flush),
    .IdEx_flush   (IdEx_flush),
    .ExMem_flush  (ExMem_flush),
    .Mdu_go       (Mdu_go),
    .Mdu_busy     (Mdu_busy),
    .Mem_err      (Mem_err),
    .Stall_cnt    (Stall_cnt)
  );

  // Clock starts high so the first falling edge is at t=5.
  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Drive all inputs of one pipeline cycle.
  task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] exRt, input logic memRead,
                               input logic br, input logic mStart,
                               input logic mUse, input logic req,
                               input logic ready);
    Id_rs        = rs;
    Id_rt        = rt;
    Ex_rt        = exRt;
    Ex_MemRead   = memRead;
    Mem_br_taken = br;
    Id_mdu_start = mStart;
    Id_mdu_use   = mUse;
    Mem_req      = req;
    Mem_ready    = ready;
  endtask

  task automatic idle();
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Single comparison point.
  task automatic checkOutput(input string tag, input logic [15:0] obs,
                             input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("[TB] %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare the whole control vector {en5, fl3, go, busy, err}.
  task automatic checkCtl(input string tag, input logic [4:0] en,
                          input logic [2:0] fl, input logic go,
                          input logic busy, input logic err);
    logic [10:0] obs;
    logic [10:0] exp;
    obs = {Pc_en, IfId_en, IdEx_en, ExMem_en, MemWb_en,
           IfId_flush, IdEx_flush, ExMem_flush, Mdu_go, Mdu_busy, Mem_err};
    exp = {en, fl, go, busy, err};
    checkOutput(tag, {5'b0, obs}, {5'b0, exp});
  endtask

  task automatic checkStall(input string tag, input logic [3:0] exp);
    checkOutput(tag, {12'b0, Stall_cnt}, {12'b0, exp});
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    // Reset: everything quiet while rst is high.
    rst = 1'b1;
    idle();
    settle();
    checkCtl("reset_ctl", EN_NONE, FL_NONE, 1'b0, 1'b0, 1'b0);
    checkStall("reset_stall", 4'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;

    // Normal advance.
    idle();
    settle();
    checkCtl("normal", EN_ALL, FL_NONE, 1'b0, 1'b0, 1'b0);
    tick();

    // Load-use: lw r8 in EX, ID reads r8 -> exactly one bubble.
    applyStimulus(5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    checkCtl("loaduse_stall", EN_STALL, FL_STALL, 1'b0, 1'b0, 1'b0);
    tick();
    checkStall("loaduse_cnt", 4'd1);
    applyStimulus(5'd8, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    checkCtl("loaduse_after", EN_ALL, FL_NONE, 1'b0, 1'b0, 1'b0);
    tick();

    // Load to $zero never stalls.
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    settle();
    checkCtl("loaduse_zero", EN_ALL, FL_NONE, 1'b0, 1'b0, 1'b0);
    tick();
    checkStall("loaduse_zero_cnt", 4'd1);

    // Branch with a simultaneous load-use and a mult in ID: flush wins,
    // mult is killed and must not launch.
    applyStimulus(5'd1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    checkCtl("branch_flush", EN_ALL, FL_ALL, 1'b0, 1'b0, 1'b0);
    tick();
    checkStall("branch_cnt", 4'd1);

    // MDU: launch, two independent cycles, then mflo stalls two cycles.
    applyStimulus(5'd2, 5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    settle();
    checkCtl("mdu_go", EN_ALL, FL_NONE, 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    settle();
    checkCtl("mdu_busy1", EN_ALL, FL_NONE, 1'b0, 1'b1, 1'b0);
    tick();
    settle();
    checkCtl("mdu_busy2", EN_ALL, FL_NONE, 1'b0, 1'b1, 1'b0);
    tick();
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    checkCtl("mflo_stall1", EN_STALL, FL_STALL, 1'b0, 1'b1, 1'b0);
    tick();
    checkStall("mflo_cnt1", 4'd2);
    settle();
    checkCtl("mflo_stall2", EN_STALL, FL_STALL, 1'b0, 1'b1, 1'b0);
    tick();
    checkStall("mflo_cnt2", 4'd3);
    settle();
    checkCtl("mflo_advance", EN_ALL, FL_NONE, 1'b0, 1'b0, 1'b0);
    tick();
    checkStall("mflo_cnt3", 4'd3);

    // Memory wait of 3 edges with a branch held in MEM.
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      settle();
      checkCtl("memwait_frozen", EN_NONE, FL_NONE, 1'b0, 1'b0, 1'b0);
      tick();
      checkStall("memwait_cnt", 4'(4 + i));
    end
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    settle();
    checkCtl("memwait_release_flush", EN_ALL, FL_ALL, 1'b0, 1'b0, 1'b0);
    tick();
    checkStall("memwait_release_cnt", 4'd6);
    idle();
    settle();
    checkCtl("memwait_run", EN_ALL, FL_NONE, 1'b0, 1'b0, 1'b0);
    tick();

    // Watchdog: 4 frozen edges -> ERR.
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
    end
    settle();
    checkCtl("wdog_pre_err", EN_NONE, FL_NONE, 1'b0, 1'b0, 1'b0);
    tick();
    checkStall("wdog_cnt", 4'd10);
    settle();
    checkCtl("wdog_err", EN_NONE, FL_NONE, 1'b0, 1'b0, 1'b1);
    idle();
    settle();
    checkCtl("wdog_err_sticky", EN_NONE, FL_NONE, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick();
    end
    checkStall("stall_saturate_err", 4'd15);

    // Asynchronous reset in the middle of a cycle acts immediately.
    #3;
    rst = 1'b1;
    #1;
    checkCtl("async_reset_ctl", EN_NONE, FL_NONE, 1'b0, 1'b0, 1'b0);
    checkStall("async_reset_cnt", 4'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    idle();
    settle();
    checkCtl("post_reset_run", EN_ALL, FL_NONE, 1'b0, 1'b0, 1'b0);
    tick();

    // Saturation: 20 frozen cycles from a clean counter.
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    checkStall("stall_saturate_freeze", 4'd15);
    settle();
    checkCtl("saturate_err", EN_NONE, FL_NONE, 1'b0, 1'b0, 1'b1);

    // Reset while the MDU is busy abandons the operation.
    rst = 1'b1;
    #1;
    @(negedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    settle();
    checkCtl("mdu_busy_pre_reset", EN_ALL, FL_NONE, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    checkCtl("mdu_reset", EN_NONE, FL_NONE, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    settle();
    checkCtl("mdu_after_reset", EN_ALL, FL_NONE, 1'b0, 1'b0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
